// File: rtl/usb_tx_scheduler.sv
// rtl/usb_tx_scheduler.sv - USB TX packet arbiter for handshake and DATA requesters (optional macro TX_TIMEOUT_EN)
module usb_tx_scheduler #(
  parameter int OCC_W          = 7,
  parameter int GAP_CYCLES     = 2
`ifdef TX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int TO_W           = 12
`endif
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             hs_req,
  input  logic [2:0]       hs_code,
  input  logic             data_req,
  input  logic [OCC_W-1:0] buffer_occupancy,
  input  logic             end_packet,
  output logic [2:0]       tx_packet,
  output logic             hs_ack,
  output logic             data_ack,
  output logic             tx_done,
  output logic             tx_error,
  output logic             busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [2:0]       r_tx_packet;
  logic             r_hs_ack;
  logic             r_data_ack;
  logic             r_tx_done;
  logic             r_tx_error;
  logic             r_busy;

  logic [2:0]       w_tx_packet_nxt;
  logic             w_hs_ack_nxt;
  logic             w_data_ack_nxt;
  logic             w_tx_done_nxt;
  logic             w_tx_error_nxt;
  logic             w_busy_nxt;

  logic             w_hs_take;
  logic             w_data_take;
  logic             w_hs_valid;
  logic             w_occ_empty;
  logic             w_gap_last;
  logic             w_timeout;

  // A request whose ack is on the wire this cycle is still high at this edge; don't serve it twice.
  assign w_hs_take   = hs_req && !r_hs_ack;
  assign w_data_take = data_req && !r_data_ack;
  assign w_hs_valid  = (hs_code == 3'd2) || (hs_code == 3'd3) || (hs_code == 3'd4);
  assign w_occ_empty = (buffer_occupancy == '0);
  assign w_gap_last  = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

`ifdef TX_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // SEND watchdog: counts cycles spent in SEND, cleared on any state change
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_to_cnt <= '0;
    else if (r_state == S_SEND && w_state_nxt == S_SEND) r_to_cnt <= r_to_cnt + 1'b1;
    else r_to_cnt <= '0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State, gap counter and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_gap_cnt   <= '0;
      r_tx_packet <= 3'd0;
      r_hs_ack    <= 1'b0;
      r_data_ack  <= 1'b0;
      r_tx_done   <= 1'b0;
      r_tx_error  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gap_cnt   <= (r_state == S_GAP && w_state_nxt == S_GAP) ? r_gap_cnt + 1'b1 : '0;
      r_tx_packet <= w_tx_packet_nxt;
      r_hs_ack    <= w_hs_ack_nxt;
      r_data_ack  <= w_data_ack_nxt;
      r_tx_done   <= w_tx_done_nxt;
      r_tx_error  <= w_tx_error_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state selection: handshakes always win over DATA in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs_take) begin
          if (w_hs_valid) w_state_nxt = S_SEND;
        end else if (w_data_take && !w_occ_empty) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND:  if (end_packet || w_timeout) w_state_nxt = S_GAP;
      S_GAP:   if (w_gap_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_tx_packet_nxt = r_tx_packet;
    w_hs_ack_nxt    = 1'b0;
    w_data_ack_nxt  = 1'b0;
    w_tx_done_nxt   = 1'b0;
    w_tx_error_nxt  = 1'b0;
    w_busy_nxt      = r_busy;
    case (r_state)
      S_IDLE: begin
        w_tx_packet_nxt = 3'd0;
        w_busy_nxt      = 1'b0;
        if (w_hs_take) begin
          w_hs_ack_nxt = 1'b1;
          if (w_hs_valid) begin
            w_tx_packet_nxt = hs_code;
            w_busy_nxt      = 1'b1;
          end else begin
            w_tx_error_nxt = 1'b1;
          end
        end else if (w_data_take) begin
          w_data_ack_nxt = 1'b1;
          if (w_occ_empty) begin
            w_tx_error_nxt = 1'b1;
          end else begin
            w_tx_packet_nxt = 3'd1;
            w_busy_nxt      = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (end_packet) begin
          w_tx_packet_nxt = 3'd0;
          w_tx_done_nxt   = 1'b1;
        end else if (w_timeout) begin
          w_tx_packet_nxt = 3'd0;
          w_tx_error_nxt  = 1'b1;
        end
      end
      S_GAP: begin
        w_tx_packet_nxt = 3'd0;
        if (w_gap_last) w_busy_nxt = 1'b0;
      end
      default: begin
        w_tx_packet_nxt = 3'd0;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  assign tx_packet = r_tx_packet;
  assign hs_ack    = r_hs_ack;
  assign data_ack  = r_data_ack;
  assign tx_done   = r_tx_done;
  assign tx_error  = r_tx_error;
  assign busy      = r_busy;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb/tb_usb_tx_scheduler.sv - randomized self-checking bench for usb_tx_scheduler
module tb_usb_tx_scheduler;

  localparam int GAP_CYCLES     = 2;
  localparam int TIMEOUT_CYCLES = 4095;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       hs_req;
  logic [2:0] hs_code;
  logic       data_req;
  logic [6:0] buffer_occupancy;
  logic       end_packet;
  logic [2:0] tx_packet;
  logic       hs_ack;
  logic       data_ack;
  logic       tx_done;
  logic       tx_error;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  usb_tx_scheduler dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .hs_req           (hs_req),
    .hs_code          (hs_code),
    .data_req         (data_req),
    .buffer_occupancy (buffer_occupancy),
    .end_packet       (end_packet),
    .tx_packet        (tx_packet),
    .hs_ack           (hs_ack),
    .data_ack         (data_ack),
    .tx_done          (tx_done),
    .tx_error         (tx_error),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [7:0] outs();
    return {tx_packet, hs_ack, data_ack, tx_done, tx_error, busy};
  endfunction

  // Packet of 'code' is visible (cycle 1 already observed). The TX controller
  // reports end_packet during visible cycle d; a watchdog, if built, caps SEND.
  task automatic send_phase(input logic [2:0] code, input int d);
    int  limit;
    bit  timed;
    limit = d;
    timed = 0;
`ifdef TX_TIMEOUT_EN
    if (d > TIMEOUT_CYCLES) begin
      limit = TIMEOUT_CYCLES;
      timed = 1;
    end
`endif
    for (int i = 1; i < limit; i++) begin
      step();
      chk("send_hold", {tx_packet, hs_ack, data_ack, tx_done, tx_error, busy}, {code, 5'b00001});
    end
    if (!timed) end_packet = 1'b1;
    step();
    end_packet = 1'b0;
    chk("send_end", outs(), {3'd0, 2'b00, !timed, timed, 1'b1});
    for (int g = 1; g < GAP_CYCLES; g++) begin
      step();
      chk("gap", outs(), 8'b000_00001);
    end
    step();
    chk("gap_exit", outs(), 8'd0);
  endtask

  // Present the requests; model: pending requests in IDLE are consumed one per
  // cycle, handshake first; a granted one runs a full SEND + GAP before the next.
  task automatic serve(input bit hs, input logic [2:0] code, input bit dr,
                       input logic [6:0] occ, input int d);
    bit hs_p;
    bit dr_p;
    bit ok;
    hs_p = hs;
    dr_p = dr;
    hs_req = hs;
    hs_code = code;
    data_req = dr;
    buffer_occupancy = occ;
    while (hs_p || dr_p) begin
      step();
      if (hs_p) begin
        ok = (code >= 3'd2) && (code <= 3'd4);
        chk("hs_resp", outs(), ok ? {code, 5'b10001} : {3'd0, 5'b10010});
        hs_p = 0;
        hs_req = 1'b0;
        if (ok) send_phase(code, d);
      end else begin
        ok = (occ != 7'd0);
        chk("data_resp", outs(), ok ? {3'd1, 5'b01001} : {3'd0, 5'b01010});
        dr_p = 0;
        data_req = 1'b0;
        if (ok) send_phase(3'd1, d);
      end
    end
    step();
    chk("idle_quiet", outs(), 8'd0);
  endtask

  initial begin
    n_rst = 1'b0;
    hs_req = 1'b0;
    hs_code = 3'd0;
    data_req = 1'b0;
    buffer_occupancy = 7'd0;
    end_packet = 1'b0;
    step();
    chk("reset_outs", outs(), 8'd0);
    step();
    n_rst = 1'b1;
    step();
    chk("post_reset", outs(), 8'd0);

    serve(1, 3'd2, 0, 7'd0, 20);
    serve(0, 3'd0, 1, 7'd0, 1);
    serve(1, 3'd3, 1, 7'd64, 20);
    serve(1, 3'd5, 0, 7'd0, 1);
    serve(1, 3'd0, 1, 7'd1, 1);

    end_packet = 1'b1;
    step();
    end_packet = 1'b0;
    step();
    chk("stray_end", outs(), 8'd0);

    for (int t = 0; t < 40; t++) begin
      bit         hs;
      bit         dr;
      logic [2:0] code;
      logic [6:0] occ;
      hs   = 1'($urandom_range(0, 1));
      dr   = 1'($urandom_range(0, 1));
      code = 3'($urandom_range(0, 7));
      occ  = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 64));
      if (!hs && !dr) dr = 1;
      serve(hs, code, dr, occ, int'($urandom_range(1, 30)));
    end

    serve(0, 3'd0, 1, 7'd8, 5001);
`ifdef TX_TIMEOUT_EN
    serve(0, 3'd0, 1, 7'd8, TIMEOUT_CYCLES);
`endif

    data_req = 1'b1;
    buffer_occupancy = 7'd8;
    step();
    chk("rst_grant", outs(), {3'd1, 5'b01001});
    data_req = 1'b0;
    repeat (3) step();
    n_rst = 1'b0;
    #1;
    chk("rst_mid_send", outs(), 8'd0);
    step();
    n_rst = 1'b1;
    step();
    chk("rst_idle", outs(), 8'd0);
    serve(0, 3'd0, 1, 7'd5, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
Arbitrates the shared USB TX packet path between two requesters: the RX-side protocol handler, which requests handshakes (ACK/NAK/STALL), and the AHB-side endpoint logic, which requests DATA packets. The block drives the TX controller's tx_packet command and holds it until end_packet. It then enforces an inter-packet gap. It validates requests before granting: empty buffer for DATA, illegal handshake code. It reports completion and errors upstream.

Parameters:
OCC_W, 7, width of buffer_occupancy (0..64 bytes)
GAP_CYCLES, 2, idle cycles forced between end_packet and next grant (min 1)
TIMEOUT_CYCLES, 4095, max cycles in SEND before abort (only with TX_TIMEOUT_EN)
TO_W, 12, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
n_rst  in  1  async active-low reset
hs_req  in  1  handshake request; held high until hs_ack
hs_code  in  3  handshake code: 2=ACK, 3=NAK, 4=STALL; sampled only when accepted
data_req  in  1  DATA packet request; held high until data_ack
buffer_occupancy  in  OCC_W  bytes currently in TX data buffer
end_packet  in  1  TX controller finished current packet (1-cycle pulse)
tx_packet  out  3  command to TX controller: 0=none, 1=DATA, 2/3/4=handshake
hs_ack  out  1  1-cycle pulse: handshake request consumed (granted or rejected)
data_ack  out  1  1-cycle pulse: data request consumed (granted or rejected)
tx_done  out  1  1-cycle pulse on successful packet completion
tx_error  out  1  1-cycle pulse on rejected request or timeout
busy  out  1  high in SEND and GAP

Behaviour:
- Interface: one clock, clk; reset n_rst is asynchronous and active-low.
- Reset: state=IDLE; tx_packet=0; hs_ack, data_ack, tx_done, tx_error, busy=0; counters=0. Reset asserted mid-packet aborts immediately with no error pulse.
- All outputs are registered.
- States: IDLE, SEND, GAP.
- IDLE, hs_req=1 (priority over data_req):
  - hs_code in {2,3,4}: latch code; next cycle tx_packet=code, hs_ack=1, busy=1; go SEND.
  - any other hs_code: next cycle hs_ack=1, tx_error=1; stay IDLE; tx_packet stays 0.
- IDLE, data_req=1 and hs_req=0:
  - buffer_occupancy==0: next cycle data_ack=1, tx_error=1; stay IDLE.
  - otherwise: next cycle tx_packet=1, data_ack=1, busy=1; go SEND.
- Request-to-tx_packet latency is 1 cycle. Ack pulses coincide with the first tx_packet cycle. A request dropped before ack is simply not served.
- SEND: tx_packet held constant. The timeout counter increments each cycle.
  - end_packet=1: next cycle tx_packet=0, tx_done=1; go GAP.
  - timeout reached (counter==TIMEOUT_CYCLES-1) and no end_packet: next cycle tx_packet=0, tx_error=1; go GAP.
  - end_packet and timeout in the same cycle: end_packet wins (tx_done, no error).
- GAP: tx_packet=0, busy=1; count GAP_CYCLES cycles, then go IDLE with busy=0. Requests arriving in SEND/GAP are not acked; the requester holds them and they are evaluated on the first IDLE cycle.
- end_packet outside SEND is ignored.
- No starvation guard: handshakes always win. This is acceptable because handshakes only follow host tokens.
- Counters reset to 0 on every state entry. No counter wraps.

Optional Feature:
Macro TX_TIMEOUT_EN.
- Defined: SEND aborts after TIMEOUT_CYCLES with tx_error, as specified above.
- Undefined: timeout counter and TIMEOUT_CYCLES logic are absent; SEND waits indefinitely for end_packet, and tx_error comes only from request rejection.

Test Plan:
1. hs_req=1, hs_code=2 in IDLE -> next cycle tx_packet=2, hs_ack=1 for 1 cycle; end_packet 20 cycles later -> tx_packet=0, tx_done=1 for 1 cycle; busy low after 2 GAP cycles.
2. data_req=1, buffer_occupancy=0 -> data_ack=1 and tx_error=1 for 1 cycle; tx_packet stays 0; busy stays 0.
3. hs_req=1 (hs_code=3) and data_req=1 (occupancy=64) in the same cycle -> tx_packet=3 first; after end_packet and 2 GAP cycles -> tx_packet=1, data_ack=1.
4. With TX_TIMEOUT_EN: data grant (occupancy=8), no end_packet for 4095 cycles -> tx_error=1, tx_packet=0, enter GAP. Without the macro -> tx_packet=1 still held after 5000 cycles.
5. hs_req=1, hs_code=5 -> hs_ack=1, tx_error=1, tx_packet stays 0. Then n_rst low mid-SEND of a DATA packet -> all outputs 0 immediately; state IDLE after release.
6. end_packet and timeout in the same cycle -> tx_done=1, tx_error=0.
